pipe_stage_hs: RTL and testbench
================================

# pipe_stage_hs

Parametrised elastic pipeline stage: a chain of DEPTH registered slots carrying a WIDTH-bit word under valid/ready flow control. It is the handshaked successor of the plain registered stage used in the pipeline exercises. It keeps that stage's "bit set in two consecutive words" detector, now per bit across consecutive delivered words. It also adds back-pressure, a synchronous flush and an occupancy count.

## Interface
- WIDTH, default 5: data word width, ≥1.
- DEPTH, default 2: number of register slots, ≥1. Sets the minimum latency.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream word valid.
- ready_o  out  1  stage can accept a word this cycle.
- data_i  in  WIDTH  upstream word.
- valid_o  out  1  head slot holds a word.
- ready_i  in  1  downstream accepts the head word.
- data_o  out  WIDTH  head word.
- persist_o  out  WIDTH  per-bit persistence flags (see Operation).
- flush_i  in  1  synchronous flush request.
- fill_o  out  $clog2(DEPTH+1)  number of occupied slots, 0..DEPTH.

## Operation
- Slots are numbered 0 (input side) to DEPTH-1 (head). Each slot holds valid_q[k] and data_q[k].
- Slot ready: rdy[k] = !valid_q[k] || rdy[k+1], with rdy[DEPTH] = ready_i. The ready path is combinational through the chain; no bubble is inserted.
- ready_o = rdy[0] && !flush_i.
- Transfer into slot k happens when the upstream side of k is valid and rdy[k] is high. Slot 0's upstream side is valid_i && !flush_i; slot k's upstream side is valid_q[k-1]. On transfer, data_q[k] takes the upstream word and valid_q[k] is set.
- Slot k clears when it hands off (rdy[k+1]) and no new word transfers in.
- A slot that is not ready holds its contents; data never changes while valid && !ready.
- valid_o = valid_q[DEPTH-1] && !flush_i; data_o = data_q[DEPTH-1].
- An output transfer happens when valid_o && ready_i.
- last_q (WIDTH bits) stores data_o on every output transfer.
- persist_o = data_o & last_q, gated to 0 when valid_o = 0. A bit is flagged when it is 1 in the head word and was 1 in the previously delivered word.
- fill_o = popcount(valid_q), registered-state derived.
- flush_i = 1 in a cycle:
  - no input accepted and no output transfer;
  - next edge clears all valid_q and last_q;
  - data_q contents are don't-care afterwards.
- Reset (asynchronous, rst_ni = 0): all valid_q = 0, data_q = 0, last_q = 0.
- Outputs during and after reset: valid_o = 0, data_o = 0, persist_o = 0, fill_o = 0, ready_o = 1 (unless flush_i).

## Timing
- Latency from input acceptance to valid_o is DEPTH cycles when downstream is always ready.
- Throughput is 1 word/cycle sustained with ready_i = 1.
- A full pipe (fill_o = DEPTH) with ready_i = 1 accepts a new word in the same cycle: ready_o = 1 and fill_o stays DEPTH.
- A full pipe with ready_i = 0 gives ready_o = 0 in the same cycle (combinational).
- ready_i deasserting stalls all slots behind the head in that cycle. No word is dropped or duplicated.
- persist_o, valid_o and data_o are valid in the same cycle as the head slot. last_q updates on the edge following the transfer.
- flush_i takes priority over simultaneous valid_i, ready_i and transfers. fill_o = 0 on the cycle after the flush.
- Reset asserted mid-transfer discards all in-flight words immediately (asynchronous). The first acceptance is possible in the first cycle after rst_ni deasserts.
- DEPTH = 1 degenerates to a single full-throughput register with a combinational ready path.

## Test plan
- Reset: rst_ni = 0 with random inputs → valid_o = 0, data_o = 0, persist_o = 0, fill_o = 0. After release, ready_o = 1.
- Streaming (WIDTH = 5, DEPTH = 2, ready_i = 1): feed 0x01, 0x03, 0x02 on consecutive cycles.
  - Words appear 2 cycles later, in order, one per cycle.
  - persist_o = 0x00, then 0x01, then 0x02.
- Back-pressure: fill the pipe, then hold ready_i = 0 for 3 cycles.
  - fill_o = 2, ready_o = 0, data_o is stable.
  - Releasing ready_i delivers both words in order, with no loss or duplication.
- Simultaneous push/pop when full with ready_i = 1: ready_o = 1 and fill_o stays 2 across 10 cycles. Output sequence equals input sequence delayed 2 cycles.
- Flush with valid_i = 1 and 2 words held: no transfer occurs. Next cycle fill_o = 0 and valid_o = 0. The next delivered word has persist_o = 0 regardless of its value.
- Async reset mid-stream: assert rst_ni = 0 between edges with fill_o = 2 → valid_o drops immediately. After release, a 0x1F input emerges alone with persist_o = 0.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Elastic pipeline stage: DEPTH handshaked register slots with a combinational ready chain,
// synchronous flush, occupancy count and per-bit persistence detection across delivered words.
module pipe_stage_hs #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [WIDTH-1:0]           data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [WIDTH-1:0]           persist_o,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH+1)-1:0] fill_o
);

   localparam int FW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [WIDTH-1:0] r_last;

   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_up_valid;
   logic [WIDTH-1:0] w_up_data [DEPTH];
   logic             w_all_full;
   logic             w_out_xfer;
   logic [FW-1:0]    w_fill;

   // A slot is ready when downstream is ready or any slot from it to the head is empty;
   // written this way so the chain has no self-referencing vector.
   always_comb begin
      w_rdy      = '0;
      w_all_full = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         w_all_full = 1'b1;
         for (int j = k; j < DEPTH; j++) begin
            w_all_full = w_all_full & r_valid[j];
         end
         w_rdy[k] = ready_i | ~w_all_full;
      end
   end

   // Upstream word feeding each slot.
   always_comb begin
      w_up_valid    = '0;
      w_up_valid[0] = valid_i;
      w_up_data[0]  = data_i;
      for (int k = 1; k < DEPTH; k++) begin
         w_up_valid[k] = r_valid[k-1];
         w_up_data[k]  = r_data[k-1];
      end
   end

   // Occupancy from the slot valid bits.
   always_comb begin
      w_fill = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_fill = w_fill + FW'(r_valid[k]);
      end
   end

   assign ready_o    = w_rdy[0] & ~flush_i;
   assign valid_o    = r_valid[DEPTH-1] & ~flush_i;
   assign data_o     = r_data[DEPTH-1];
   assign persist_o  = valid_o ? (data_o & r_last) : {WIDTH{1'b0}};
   assign fill_o     = w_fill;
   assign w_out_xfer = valid_o & ready_i;

   // Slot chain: a ready slot loads its upstream word (or empties); flush wins over everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
         end
      end else if (flush_i) begin
         r_valid <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_rdy[k]) begin
               r_valid[k] <= w_up_valid[k];
               if (w_up_valid[k]) begin
                  r_data[k] <= w_up_data[k];
               end
            end
         end
      end
   end

   // Remember the last delivered word for persistence detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= '0;
      end else if (flush_i) begin
         r_last <= '0;
      end else if (w_out_xfer) begin
         r_last <= data_o;
      end
   end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: a queue-based occupancy model checked every cycle,
// plus literal expectations on the delivered word/persistence log.
module tb_pipe_stage_hs;

   localparam int WIDTH = 5;
   localparam int DEPTH = 2;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;
   logic [WIDTH-1:0] persist_o;
   logic             flush_i;
   logic [1:0]       fill_o;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      logic [WIDTH-1:0] d;
      int               pos;
   } ent_t;

   ent_t             mq[$];
   logic [WIDTH-1:0] m_last;
   logic [WIDTH-1:0] log_d[$];
   logic [WIDTH-1:0] log_p[$];

   pipe_stage_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .persist_o(persist_o), .flush_i(flush_i), .fill_o(fill_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
      valid_i = v;
      data_i  = d;
      ready_i = r;
      flush_i = f;
      @(posedge clk_i);
      #1;
   endtask

   // Model: in-order queue of words with slot positions; checked on every falling edge
   initial begin
      int          n;
      logic        head_v, e_ready, e_valid, acc;
      logic [WIDTH-1:0] e_pers;
      int          lim;
      ent_t        e;
      m_last = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            chk("rst_valid_o", 32'(valid_o), 32'd0);
            chk("rst_data_o", 32'(data_o), 32'd0);
            chk("rst_persist_o", 32'(persist_o), 32'd0);
            chk("rst_fill_o", 32'(fill_o), 32'd0);
            chk("rst_ready_o", 32'(ready_o), 32'(!flush_i));
            mq.delete();
            m_last = '0;
         end else begin
            n       = mq.size();
            head_v  = (n > 0) && (mq[0].pos == DEPTH-1);
            e_ready = (ready_i || n < DEPTH) && !flush_i;
            e_valid = head_v && !flush_i;
            e_pers  = e_valid ? (mq[0].d & m_last) : '0;
            chk("ready_o", 32'(ready_o), 32'(e_ready));
            chk("valid_o", 32'(valid_o), 32'(e_valid));
            chk("fill_o", 32'(fill_o), 32'(n));
            chk("persist_o", 32'(persist_o), 32'(e_pers));
            if (e_valid) chk("data_o", 32'(data_o), 32'(mq[0].d));
            if (valid_o && ready_i) begin
               log_d.push_back(data_o);
               log_p.push_back(persist_o);
            end
            acc = e_ready && valid_i;
            if (flush_i) begin
               mq.delete();
               m_last = '0;
            end else begin
               if (e_valid && ready_i) begin
                  m_last = mq[0].d;
                  void'(mq.pop_front());
               end
               for (int i = 0; i < mq.size(); i++) begin
                  lim = (i == 0) ? DEPTH-1 : mq[i-1].pos - 1;
                  if (mq[i].pos < lim) mq[i].pos = mq[i].pos + 1;
               end
               if (acc) begin
                  e.d   = data_i;
                  e.pos = 0;
                  mq.push_back(e);
               end
            end
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] exp_seq[$];
      rst_ni  = 1'b0;
      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      end
      rst_ni = 1'b1;
      drive(1'b0, 5'h00, 1'b1, 1'b0);
      chk("ready_after_reset", 32'(ready_o), 32'd1);

      // Streaming
      log_d.delete(); log_p.delete();
      drive(1'b1, 5'h01, 1'b1, 1'b0);
      drive(1'b1, 5'h03, 1'b1, 1'b0);
      drive(1'b1, 5'h02, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 5'h00, 1'b1, 1'b0);
      chk("stream_count", 32'(log_d.size()), 32'd3);
      if (log_d.size() == 3) begin
         chk("stream_d0", 32'(log_d[0]), 32'h01);
         chk("stream_d1", 32'(log_d[1]), 32'h03);
         chk("stream_d2", 32'(log_d[2]), 32'h02);
         chk("stream_p0", 32'(log_p[0]), 32'h00);
         chk("stream_p1", 32'(log_p[1]), 32'h01);
         chk("stream_p2", 32'(log_p[2]), 32'h02);
      end

      // Back-pressure
      log_d.delete(); log_p.delete();
      drive(1'b1, 5'h0A, 1'b0, 1'b0);
      drive(1'b1, 5'h0B, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_fill", 32'(fill_o), 32'd2);
         chk("bp_ready", 32'(ready_o), 32'd0);
         chk("bp_data", 32'(data_o), 32'h0A);
         drive(1'b1, 5'h15, 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 5'h00, 1'b1, 1'b0);
      chk("bp_count", 32'(log_d.size()), 32'd2);
      if (log_d.size() == 2) begin
         chk("bp_d0", 32'(log_d[0]), 32'h0A);
         chk("bp_d1", 32'(log_d[1]), 32'h0B);
         chk("bp_p0", 32'(log_p[0]), 32'h02);
         chk("bp_p1", 32'(log_p[1]), 32'h0A);
      end

      // Full pipe with simultaneous push and pop
      log_d.delete(); log_p.delete();
      exp_seq.delete();
      drive(1'b1, 5'h10, 1'b0, 1'b0);
      drive(1'b1, 5'h11, 1'b0, 1'b0);
      exp_seq.push_back(5'h10);
      exp_seq.push_back(5'h11);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'(8'h12 + i), 1'b1, 1'b0);
         exp_seq.push_back(5'(8'h12 + i));
         chk("pp_fill", 32'(fill_o), 32'd2);
         chk("pp_ready", 32'(ready_o), 32'd1);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 5'h00, 1'b1, 1'b0);
      chk("pp_count", 32'(log_d.size()), 32'd12);
      if (log_d.size() == 12) begin
         for (int i = 0; i < 12; i++) chk("pp_seq", 32'(log_d[i]), 32'(exp_seq[i]));
      end

      // Flush with two words held and valid_i asserted
      drive(1'b1, 5'h05, 1'b0, 1'b0);
      drive(1'b1, 5'h06, 1'b0, 1'b0);
      log_d.delete(); log_p.delete();
      drive(1'b1, 5'h1F, 1'b1, 1'b1);
      chk("flush_fill", 32'(fill_o), 32'd0);
      chk("flush_valid", 32'(valid_o), 32'd0);
      chk("flush_no_xfer", 32'(log_d.size()), 32'd0);
      drive(1'b1, 5'h1F, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 5'h00, 1'b1, 1'b0);
      chk("flush_count", 32'(log_d.size()), 32'd1);
      if (log_d.size() == 1) begin
         chk("flush_d", 32'(log_d[0]), 32'h1F);
         chk("flush_p", 32'(log_p[0]), 32'h00);
      end

      // Asynchronous reset mid-stream
      drive(1'b1, 5'h03, 1'b0, 1'b0);
      drive(1'b1, 5'h07, 1'b0, 1'b0);
      chk("pre_rst_fill", 32'(fill_o), 32'd2);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_valid", 32'(valid_o), 32'd0);
      chk("async_fill", 32'(fill_o), 32'd0);
      chk("async_data", 32'(data_o), 32'd0);
      valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      log_d.delete(); log_p.delete();
      drive(1'b1, 5'h1F, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 5'h00, 1'b1, 1'b0);
      chk("arst_count", 32'(log_d.size()), 32'd1);
      if (log_d.size() == 1) begin
         chk("arst_d", 32'(log_d[0]), 32'h1F);
         chk("arst_p", 32'(log_p[0]), 32'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
